// File: rtl/my_pkg.sv
// Shared FSM/section types and default section sizes for weight_load_ctrl.
package my_pkg;
  localparam int KERNEL_NUM_DEF = 81;
  localparam int BIAS_NUM_DEF   = 12;
  localparam int SCALE_NUM_DEF  = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} wl_state_e;
  typedef enum logic [1:0] {SEC_KERNEL, SEC_BIAS, SEC_SCALE, SEC_CFG} wl_sec_e;

  // Sections are contiguous; an empty section has coincident bounds and never matches.
  function automatic wl_sec_e section_of(
    input logic [15:0] idx,
    input logic [15:0] bias_start,
    input logic [15:0] scale_start,
    input logic [15:0] cfg_idx
  );
    wl_sec_e sec;
    if (idx < bias_start)       sec = SEC_KERNEL;
    else if (idx < scale_start) sec = SEC_BIAS;
    else if (idx < cfg_idx)     sec = SEC_SCALE;
    else                        sec = SEC_CFG;
    return sec;
  endfunction
endpackage

// File: rtl/weight_load_ctrl.sv
// Streams kernel/bias/scale/cfg words from memory into their destination buffers.
// Optional XOR checksum output is built when WEIGHT_LOAD_CHECKSUM_EN is defined.
module weight_load_ctrl
  import my_pkg::*;
#(
  parameter int          pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
  parameter int          pKERNEL_NUM        = KERNEL_NUM_DEF,
  parameter int          pBIAS_NUM          = BIAS_NUM_DEF,
  parameter int          pDEQUANT_SCALE_NUM = SCALE_NUM_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   rd_addr,
  output logic                          rd_req,
  input  logic                          rd_ready,
  input  logic [pWEIGHT_DATA_WIDTH-1:0] rd_data,
  input  logic                          rd_data_vld,
  output logic [pWEIGHT_DATA_WIDTH-1:0] wr_data,
  output logic                          kernel_we,
  output logic                          bias_we,
  output logic                          scale_we,
  output logic                          cfg_we,
  output logic [15:0]                   wr_addr
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  ,
  output logic [pWEIGHT_DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [15:0] LP_BIAS_START  = 16'(pKERNEL_NUM);
  localparam logic [15:0] LP_SCALE_START = 16'(pKERNEL_NUM + pBIAS_NUM);
  localparam logic [15:0] LP_CFG_IDX     = 16'(pKERNEL_NUM + pBIAS_NUM + pDEQUANT_SCALE_NUM);
  localparam logic [31:0] LP_ADDR_STEP   = 32'(pWEIGHT_DATA_WIDTH / 8);

  wl_state_e                     r_state;
  logic [15:0]                   r_word_cnt;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_rd_req;
  logic [31:0]                   r_rd_addr;
  logic [pWEIGHT_DATA_WIDTH-1:0] r_wr_data;
  logic [15:0]                   r_wr_addr;
  logic                          r_kernel_we;
  logic                          r_bias_we;
  logic                          r_scale_we;
  logic                          r_cfg_we;

  wl_sec_e                       w_sec;
  logic [15:0]                   w_offset;

  always_comb begin
    w_offset = '0;
    w_sec    = section_of(r_word_cnt, LP_BIAS_START, LP_SCALE_START, LP_CFG_IDX);
    unique case (w_sec)
      SEC_KERNEL: w_offset = r_word_cnt;
      SEC_BIAS:   w_offset = r_word_cnt - LP_BIAS_START;
      SEC_SCALE:  w_offset = r_word_cnt - LP_SCALE_START;
      SEC_CFG:    w_offset = '0;
    endcase
  end

  // NOTE: rst is tested inside the clocked block, so reset is synchronous; all state uses <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= pWEIGHT_BASE_ADDR;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_kernel_we <= 1'b0;
      r_bias_we   <= 1'b0;
      r_scale_we  <= 1'b0;
      r_cfg_we    <= 1'b0;
    end else begin
      r_kernel_we <= 1'b0;
      r_bias_we   <= 1'b0;
      r_scale_we  <= 1'b0;
      r_cfg_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_REQ;
            r_busy     <= 1'b1;
            r_rd_req   <= 1'b1;
            r_rd_addr  <= pWEIGHT_BASE_ADDR;
            r_word_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (rd_ready) begin
            r_rd_req <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rd_data_vld) begin
            r_wr_data   <= rd_data;
            r_wr_addr   <= w_offset;
            r_kernel_we <= (w_sec == SEC_KERNEL);
            r_bias_we   <= (w_sec == SEC_BIAS);
            r_scale_we  <= (w_sec == SEC_SCALE);
            r_cfg_we    <= (w_sec == SEC_CFG);
            r_rd_addr   <= r_rd_addr + LP_ADDR_STEP;
            r_word_cnt  <= r_word_cnt + 16'd1;
            // The cfg word is always last, so it ends the load.
            if (w_sec == SEC_CFG) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_REQ;
              r_rd_req <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  logic [pWEIGHT_DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst)                                     r_checksum <= '0;
    else if (r_state == ST_IDLE && start)        r_checksum <= '0;
    else if (r_state == ST_WAIT && rd_data_vld)  r_checksum <= r_checksum ^ rd_data;
  end

  assign checksum = r_checksum;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_req    = r_rd_req;
  assign rd_addr   = r_rd_addr;
  assign wr_data   = r_wr_data;
  assign wr_addr   = r_wr_addr;
  assign kernel_we = r_kernel_we;
  assign bias_we   = r_bias_we;
  assign scale_we  = r_scale_we;
  assign cfg_we    = r_cfg_we;

endmodule
